// File: rtl/cpu_pkg.sv
// Shared encodings for the unified-memory arbiter.
// FSM state and grant-id types used by mem_arbiter.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable up-counter that flags the memory read-data cycle.
// tc is high once the count reaches WAIT_STATES-1.
module mem_wait_counter #(
    parameter int WAIT_STATES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int CW = $clog2(WAIT_STATES + 1);

    logic [CW-1:0] cnt;

    // Holds at terminal count so it can never wrap.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (inc && !tc) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = (cnt == CW'(WAIT_STATES - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-port fixed-latency memory.
// Data wins, except fetch is forced in after MAX_D_BURST data grants.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int WAIT_STATES = 2,
    parameter int MAX_D_BURST = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              core_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int BW = $clog2(MAX_D_BURST + 1);

    state_t        state;
    state_t        state_nxt;
    gnt_t          gnt;
    logic [BW-1:0] burst;
    logic          burst_full;
    logic          take_if;
    logic          take_d;
    logic          tc;
    logic          cap;

    assign burst_full = (burst == BW'(MAX_D_BURST));
    assign cap        = (state == WAIT) && tc;
    assign core_stall = (if_req & ~if_done) | (d_req & ~d_done);

    mem_wait_counter #(
        .WAIT_STATES(WAIT_STATES)
    ) u_wait (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (state == ISSUE),
        .inc  (state == WAIT),
        .tc   (tc)
    );

    always_comb begin
        state_nxt = state;
        take_if   = 1'b0;
        take_d    = 1'b0;
        unique case (state)
            IDLE: begin
                if (if_req && (!d_req || burst_full)) begin
                    take_if   = 1'b1;
                    state_nxt = ISSUE;
                end else if (d_req) begin
                    take_d    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (tc) begin
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt       <= GNT_IF;
            burst     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
        end else begin
            mem_en  <= take_if | take_d;
            if_done <= cap && (gnt == GNT_IF);
            d_done  <= cap && (gnt == GNT_D);
            if (take_if) begin
                gnt      <= GNT_IF;
                burst    <= '0;
                mem_addr <= if_addr;
                mem_we   <= 1'b0;
            end
            if (take_d) begin
                gnt       <= GNT_D;
                mem_addr  <= d_addr;
                mem_we    <= d_we;
                mem_wdata <= d_wdata;
                // Only a fetch kept waiting counts toward the burst limit.
                burst     <= if_req ? burst + BW'(1) : '0;
            end
            if (cap) begin
                if (gnt == GNT_IF) begin
                    if_rdata <= mem_rdata;
                end else if (!mem_we) begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: three instances (WAIT_STATES 2, 1, 15)
// with cycle-exact memory models; a monitor checks every done pulse.
module tb_mem_arbiter;

    localparam int N = 3;
    localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

    typedef struct {
        int          inst;
        bit          is_d;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req     [N];
    logic        d_req      [N];
    logic        d_we       [N];
    logic        if_done    [N];
    logic        d_done     [N];
    logic        core_stall [N];
    logic        mem_en     [N];
    logic        mem_we     [N];
    logic [63:0] if_addr    [N];
    logic [63:0] if_rdata   [N];
    logic [63:0] d_addr     [N];
    logic [63:0] d_wdata    [N];
    logic [63:0] d_rdata    [N];
    logic [63:0] mem_addr   [N];
    logic [63:0] mem_wdata  [N];

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : gen_dut
        localparam int WS = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        logic [63:0] mrd = JUNK;
        logic [63:0] rd_val = '0;
        int          rem = 0;
        logic [63:0] store [logic [63:0]];

        initial begin
            store[64'h40]  = 64'h8B02_0020;
            store[64'h44]  = 64'hF840_03E1;
            store[64'h48]  = 64'hD280_0020;
            store[64'h4C]  = 64'h9100_0421;
            store[64'h200] = 64'h1111;
            store[64'h208] = 64'h2222;
            store[64'h210] = 64'h3333;
            store[64'h300] = 64'hCAFE_F00D_1234_5678;
        end

        mem_arbiter #(
            .ADDR_W(64), .DATA_W(64), .WAIT_STATES(WS), .MAX_D_BURST(2)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_rdata  (if_rdata[g]),
            .if_done   (if_done[g]),
            .d_req     (d_req[g]),
            .d_we      (d_we[g]),
            .d_addr    (d_addr[g]),
            .d_wdata   (d_wdata[g]),
            .d_rdata   (d_rdata[g]),
            .d_done    (d_done[g]),
            .core_stall(core_stall[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mrd)
        );

        // Read data is valid only in the cycle WS after mem_en; junk otherwise.
        always @(negedge clk) begin
            mrd = JUNK;
            if (rem > 0) begin
                rem = rem - 1;
                if (rem == 0) mrd = rd_val;
            end
            if (mem_en[g] === 1'b1) begin
                if (mem_we[g]) store[mem_addr[g]] = mem_wdata[g];
                rd_val = store.exists(mem_addr[g]) ? store[mem_addr[g]] : ~mem_addr[g];
                rem = WS;
            end
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(int g, bit is_d);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_d ? d_done[g] : if_done[g]) && n < 40);
        if (!(is_d ? d_done[g] : if_done[g])) begin
            checks++;
            failures++;
            $display("FAIL timeout: inst %0d is_d %0d got no done, expected one", g, is_d);
        end
        next_cycle();
    endtask

    task automatic hold_if(int g, logic [63:0] a);
        if_addr[g] = a;
        if_req[g]  = 1'b1;
        wait_done(g, 1'b0);
        if_req[g]  = 1'b0;
    endtask

    task automatic hold_d(int g, logic we, logic [63:0] a, logic [63:0] wd, int n);
        d_we[g]    = we;
        d_wdata[g] = wd;
        d_req[g]   = 1'b1;
        for (int i = 0; i < n; i++) begin
            d_addr[g] = a + 64'(8 * i);
            wait_done(g, 1'b1);
        end
        d_req[g] = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < N; g++) begin
            if (if_done[g] || d_done[g]) begin
                chk("one_done", 64'(if_done[g] & d_done[g]), 64'd0);
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: inst %0d at cycle %0d, expected none", g, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("inst", 64'(g), 64'(e.inst));
                    chk("port", 64'(d_done[g]), 64'(e.is_d));
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    chk("rdata", e.is_d ? d_rdata[g] : if_rdata[g], e.data);
                end
            end
        end
    end

    initial begin
        int c0;
        for (int g = 0; g < N; g++) begin
            if_req[g]  = 1'b0;
            d_req[g]   = 1'b0;
            d_we[g]    = 1'b0;
            if_addr[g] = '0;
            d_addr[g]  = '0;
            d_wdata[g] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_if_done", 64'(if_done[0]), 64'd0);
        chk("rst_d_done", 64'(d_done[0]), 64'd0);
        chk("rst_mem_en", 64'(mem_en[0]), 64'd0);
        chk("rst_mem_we", 64'(mem_we[0]), 64'd0);
        chk("rst_mem_addr", mem_addr[0], 64'd0);
        chk("rst_mem_wdata", mem_wdata[0], 64'd0);
        chk("rst_if_rdata", if_rdata[0], 64'd0);
        chk("rst_d_rdata", d_rdata[0], 64'd0);
        chk("rst_stall", 64'(core_stall[0]), 64'd0);
        next_cycle();

        // Single fetch
        c0 = cyc;
        sbq.push_back('{inst: 0, is_d: 0, data: 64'h8B02_0020, cyc: c0 + 4});
        fork
            hold_if(0, 64'h40);
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                chk("t1_stall", 64'(core_stall[0]), (k < 4) ? 64'd1 : 64'd0);
                if (k == 1) begin
                    chk("t1_mem_en", 64'(mem_en[0]), 64'd1);
                    chk("t1_mem_addr", mem_addr[0], 64'h40);
                    chk("t1_mem_we", 64'(mem_we[0]), 64'd0);
                end
            end
        join
        next_cycle();

        // Store then load
        c0 = cyc;
        sbq.push_back('{inst: 0, is_d: 1, data: 64'h0, cyc: c0 + 4});
        fork
            hold_d(0, 1'b1, 64'h100, 64'hDEAD_BEEF, 1);
            begin
                repeat (2) @(negedge clk);
                chk("t2_mem_en", 64'(mem_en[0]), 64'd1);
                chk("t2_mem_we", 64'(mem_we[0]), 64'd1);
                chk("t2_mem_wdata", mem_wdata[0], 64'hDEAD_BEEF);
                chk("t2_mem_addr", mem_addr[0], 64'h100);
            end
        join
        next_cycle();
        c0 = cyc;
        sbq.push_back('{inst: 0, is_d: 1, data: 64'hDEAD_BEEF, cyc: c0 + 4});
        hold_d(0, 1'b0, 64'h100, 64'h0, 1);
        next_cycle();

        // Simultaneous requests: data first
        c0 = cyc;
        sbq.push_back('{inst: 0, is_d: 1, data: 64'h1111, cyc: c0 + 4});
        sbq.push_back('{inst: 0, is_d: 0, data: 64'h9100_0421, cyc: c0 + 9});
        fork
            hold_d(0, 1'b0, 64'h200, 64'h0, 1);
            hold_if(0, 64'h4C);
        join
        next_cycle();

        // Anti-starvation: D, D, IF, D
        c0 = cyc;
        sbq.push_back('{inst: 0, is_d: 1, data: 64'h1111, cyc: c0 + 4});
        sbq.push_back('{inst: 0, is_d: 1, data: 64'h2222, cyc: c0 + 9});
        sbq.push_back('{inst: 0, is_d: 0, data: 64'hF840_03E1, cyc: c0 + 14});
        sbq.push_back('{inst: 0, is_d: 1, data: 64'h3333, cyc: c0 + 19});
        fork
            hold_d(0, 1'b0, 64'h200, 64'h0, 3);
            hold_if(0, 64'h44);
        join
        next_cycle();

        // Reset in the WAIT cycle of a load
        d_addr[0] = 64'h208;
        d_we[0]   = 1'b0;
        d_req[0]  = 1'b1;
        next_cycle();
        next_cycle();
        rst_n    = 1'b0;
        d_req[0] = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_if_rdata", if_rdata[0], 64'd0);
        chk("t5_d_rdata", d_rdata[0], 64'd0);
        chk("t5_mem_en", 64'(mem_en[0]), 64'd0);
        chk("t5_mem_addr", mem_addr[0], 64'd0);
        chk("t5_mem_we", 64'(mem_we[0]), 64'd0);
        chk("t5_mem_wdata", mem_wdata[0], 64'd0);
        repeat (4) next_cycle();
        c0 = cyc;
        sbq.push_back('{inst: 0, is_d: 1, data: 64'hDEAD_BEEF, cyc: c0 + 4});
        hold_d(0, 1'b0, 64'h100, 64'h0, 1);
        next_cycle();

        // Latency sweep
        c0 = cyc;
        sbq.push_back('{inst: 1, is_d: 0, data: 64'hD280_0020, cyc: c0 + 3});
        hold_if(1, 64'h48);
        next_cycle();
        c0 = cyc;
        sbq.push_back('{inst: 2, is_d: 1, data: 64'hCAFE_F00D_1234_5678, cyc: c0 + 17});
        hold_d(2, 1'b0, 64'h300, 64'h0, 1);

        repeat (4) next_cycle();
        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
